// File: rtl/vc_wrr_arbiter_pkg.sv
// Shared types and constants for the two-VC weighted round-robin arbiter.
package vc_wrr_arbiter_pkg;

  localparam int unsigned VC_DATA_W = 6;
  localparam int unsigned VC_ID_W   = 1;
  localparam int unsigned QUOTA_W   = 3;

  typedef enum logic [VC_ID_W-1:0] {
    ST_SERVE0 = 1'b0,
    ST_SERVE1 = 1'b1
  } vc_state_e;

  // Round quota belonging to the VC served in state st.
  function automatic logic [QUOTA_W-1:0] quota_of(input vc_state_e st,
                                                  input int unsigned w0,
                                                  input int unsigned w1);
    return (st == ST_SERVE1) ? QUOTA_W'(w1) : QUOTA_W'(w0);
  endfunction

endpackage

// File: rtl/vc_wrr_arbiter_if.sv
// FIFO-side and downstream-side signals of the arbiter.
interface vc_wrr_arbiter_if
  import vc_wrr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = VC_DATA_W
);

  logic              vc0_empty;
  logic              vc1_empty;
  logic [DATA_W-1:0] vc0_data;
  logic [DATA_W-1:0] vc1_data;
  logic              ds_almost_full;
  logic              pop_vc0;
  logic              pop_vc1;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              active_vc;

  modport master (
    input  vc0_empty, vc1_empty, vc0_data, vc1_data, ds_almost_full,
    output pop_vc0, pop_vc1, data_out, valid_out, active_vc
  );

  modport slave (
    output vc0_empty, vc1_empty, vc0_data, vc1_data, ds_almost_full,
    input  pop_vc0, pop_vc1, data_out, valid_out, active_vc
  );

endinterface

// File: rtl/vc_wrr_arbiter_quota.sv
// Per-round pop quota: loadable down-counter with an "expires on this pop" flag.
module vc_wrr_arbiter_quota
  import vc_wrr_arbiter_pkg::*;
#(
  parameter logic [QUOTA_W-1:0] RST_VAL = QUOTA_W'(3)
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               load,
  input  logic [QUOTA_W-1:0] load_val,
  input  logic               dec,
  output logic               zero_next_c
);

  logic [QUOTA_W-1:0] cnt;

  // Load has priority over decrement; loads are always >= 1.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - QUOTA_W'(1);
    end
  end

  // A decrement now would take the count to zero.
  assign zero_next_c = (cnt == QUOTA_W'(1));

endmodule

// File: rtl/vc_wrr_arbiter.sv
// Weighted round-robin merge of VC0/VC1 FIFOs onto one stream with
// almost-full backpressure; work-conserving, one word per cycle.
module vc_wrr_arbiter
  import vc_wrr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = VC_DATA_W,
  parameter int unsigned W0     = 3,
  parameter int unsigned W1     = 1
) (
  input  logic             clk,
  input  logic             reset_L,
  vc_wrr_arbiter_if.master bus
);

  vc_state_e          state, state_nxt, oth, sel_c;
  logic               own_empty, oth_empty;
  logic               pop_c;
  logic               q_load, q_dec, q_zero_next_c;
  logic [QUOTA_W-1:0] q_load_val;
  logic               pop_d, sel_d;
  logic               valid_q;
  logic [DATA_W-1:0]  data_q, word_sel;

  vc_wrr_arbiter_quota #(
    .RST_VAL (QUOTA_W'(W0))
  ) u_quota (
    .clk         (clk),
    .reset_L     (reset_L),
    .load        (q_load),
    .load_val    (q_load_val),
    .dec         (q_dec),
    .zero_next_c (q_zero_next_c)
  );

  // Pop decode and next-state: serve own VC until quota expires, fall over
  // to the other VC the same cycle when own VC is empty.
  always_comb begin
    state_nxt  = state;
    pop_c      = 1'b0;
    sel_c      = state;
    q_load     = 1'b0;
    q_dec      = 1'b0;
    q_load_val = quota_of(state, W0, W1);
    oth        = (state == ST_SERVE0) ? ST_SERVE1 : ST_SERVE0;
    own_empty  = (state == ST_SERVE0) ? bus.vc0_empty : bus.vc1_empty;
    oth_empty  = (state == ST_SERVE0) ? bus.vc1_empty : bus.vc0_empty;
    if (reset_L && !bus.ds_almost_full) begin
      if (!own_empty) begin
        pop_c = 1'b1;
        if (q_zero_next_c) begin
          q_load = 1'b1;
          if (!oth_empty) begin
            state_nxt  = oth;
            q_load_val = quota_of(oth, W0, W1);
          end
        end else begin
          q_dec = 1'b1;
        end
      end else if (!oth_empty) begin
        // The switching pop counts against the new round; a weight of 1
        // is already spent, and own VC is empty, so the round restarts.
        pop_c      = 1'b1;
        sel_c      = oth;
        state_nxt  = oth;
        q_load     = 1'b1;
        q_load_val = (quota_of(oth, W0, W1) == QUOTA_W'(1)) ?
                     QUOTA_W'(1) : quota_of(oth, W0, W1) - QUOTA_W'(1);
      end
    end
  end

  assign bus.pop_vc0 = pop_c && (sel_c == ST_SERVE0);
  assign bus.pop_vc1 = pop_c && (sel_c == ST_SERVE1);

  // FSM state register; doubles as the registered active_vc.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state <= ST_SERVE0;
    end else begin
      state <= state_nxt;
    end
  end

  assign word_sel = sel_d ? bus.vc1_data : bus.vc0_data;

  // In-flight tracking and output stage: FIFO data lands one cycle after
  // the pop, and is registered onto data_out the cycle after that.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pop_d   <= 1'b0;
      sel_d   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      pop_d   <= pop_c;
      sel_d   <= (sel_c == ST_SERVE1);
      valid_q <= pop_d;
      if (pop_d) begin
        data_q <= word_sel;
      end
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.active_vc = (state == ST_SERVE1);

endmodule

// File: tb/tb_vc_wrr_arbiter.sv
// Scoreboard bench for vc_wrr_arbiter: a WRR reference model predicts pops
// and output words; a monitor checks data_out/valid_out every cycle.
module tb_vc_wrr_arbiter;
  import vc_wrr_arbiter_pkg::*;

  localparam int unsigned DW = 6;
  localparam int W0 = 3;
  localparam int W1 = 1;

  typedef struct {
    logic [DW-1:0] w;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic reset_L;
  always #5 clk = ~clk;

  vc_wrr_arbiter_if #(.DATA_W(DW)) bus();

  vc_wrr_arbiter #(.DATA_W(DW), .W0(W0), .W1(W1)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  exp_t          exp_q[$];
  logic [DW-1:0] obs[$];
  logic [DW-1:0] last_data;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int mvc, mcred;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, req);
    end
  endtask

  function automatic void refresh();
    bus.vc0_empty = (q0.size() == 0);
    bus.vc1_empty = (q1.size() == 0);
  endfunction

  // Reference WRR: credits per round, same-cycle fallover when own VC empty.
  task automatic model_step(output bit mp, output int mv);
    int  w[2];
    bit  e[2];
    w[0] = W0; w[1] = W1;
    e[0] = (q0.size() == 0); e[1] = (q1.size() == 0);
    mp = 1'b0; mv = 0;
    if (bus.ds_almost_full || (e[0] && e[1])) return;
    mp = 1'b1;
    if (!e[mvc]) begin
      mv = mvc;
      mcred--;
      if (mcred == 0) begin
        if (!e[1 - mvc]) mvc = 1 - mvc;
        mcred = w[mvc];
      end
    end else begin
      mv = 1 - mvc;
      mvc = mv;
      mcred = w[mv] - 1;
      if (mcred == 0) mcred = w[mv];
    end
  endtask

  // One clock: predict and check at negedge, move FIFOs after posedge.
  task automatic cycle(input int r0, input int r1, input bit af);
    bit mp;
    int mv;
    logic cap0, cap1;
    @(negedge clk);
    if (reset_L) begin
      check("active_vc", 32'(bus.active_vc), 32'(mvc));
      model_step(mp, mv);
      check("pop_vc0", 32'(bus.pop_vc0), 32'(mp && mv == 0));
      check("pop_vc1", 32'(bus.pop_vc1), 32'(mp && mv == 1));
      if (mp) begin
        exp_t e;
        e.w = (mv == 1) ? q1[0] : q0[0];
        e.due = cyc + 2;
        exp_q.push_back(e);
      end
    end else begin
      check("rst_pops", 32'({bus.pop_vc0, bus.pop_vc1}), 32'd0);
      check("rst_active_vc", 32'(bus.active_vc), 32'd0);
    end
    cap0 = bus.pop_vc0;
    cap1 = bus.pop_vc1;
    @(posedge clk);
    #1;
    if (reset_L) begin
      if (cap0 && q0.size() > 0) bus.vc0_data = q0.pop_front();
      if (cap1 && q1.size() > 0) bus.vc1_data = q1.pop_front();
    end
    if ($urandom_range(99) < r0) q0.push_back({2'b01, 4'($urandom)});
    if ($urandom_range(99) < r1) q1.push_back({2'b11, 4'($urandom)});
    bus.ds_almost_full = af;
    refresh();
  endtask

  task automatic reset_for(input int n, input bit fill);
    reset_L = 1'b0;
    q0.delete(); q1.delete(); exp_q.delete(); obs.delete();
    if (fill) begin
      q0.push_back(6'h11); q1.push_back(6'h32);
    end
    bus.vc0_data = '0; bus.vc1_data = '0;
    bus.ds_almost_full = 1'b0;
    refresh();
    mvc = 0; mcred = W0;
    repeat (n) cycle(0, 0, 1'b0);
    q0.delete(); q1.delete();
    refresh();
    reset_L = 1'b1;
  endtask

  task automatic check_obs(input string nm, input logic [DW-1:0] ref_w[$]);
    check({nm, "_count"}, 32'(obs.size()), 32'(ref_w.size()));
    for (int i = 0; i < ref_w.size() && i < obs.size(); i++)
      check({nm, "_word"}, 32'(obs[i]), 32'(ref_w[i]));
  endtask

  // Monitor: expected word is due exactly two cycles after its pop.
  initial begin
    last_data = '0;
    forever begin
      @(negedge clk);
      if (!reset_L) begin
        check("rst_valid_out", 32'(bus.valid_out), 32'd0);
        check("rst_data_out", 32'(bus.data_out), 32'd0);
        last_data = '0;
      end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        check("valid_out", 32'(bus.valid_out), 32'd1);
        check("data_out", 32'(bus.data_out), 32'(e.w));
        obs.push_back(bus.data_out);
        last_data = e.w;
      end else begin
        check("idle_valid_out", 32'(bus.valid_out), 32'd0);
        check("hold_data_out", 32'(bus.data_out), 32'(last_data));
      end
    end
  end

  initial begin
    logic [DW-1:0] ref_w[$];

    // Reset with non-empty FIFOs.
    reset_for(2, 1'b1);

    // Weighted order 3:1.
    q0 = '{6'b01_0001, 6'b01_0100, 6'b01_0101, 6'b01_0110};
    q1 = '{6'b11_0010, 6'b11_0011};
    refresh();
    repeat (10) cycle(0, 0, 1'b0);
    ref_w = '{6'b01_0001, 6'b01_0100, 6'b01_0101, 6'b11_0010, 6'b01_0110, 6'b11_0011};
    check_obs("wrr_order", ref_w);

    // VC1 empty: VC0 drains back-to-back.
    reset_for(1, 1'b0);
    q0 = '{6'h11, 6'h12, 6'h13, 6'h14, 6'h15};
    refresh();
    repeat (9) cycle(0, 0, 1'b0);
    ref_w = '{6'h11, 6'h12, 6'h13, 6'h14, 6'h15};
    check_obs("work_conserving", ref_w);

    // Almost-full window mid-stream.
    reset_for(1, 1'b0);
    q0 = '{6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h16};
    q1 = '{6'h31, 6'h32, 6'h33};
    refresh();
    repeat (2) cycle(0, 0, 1'b0);
    repeat (3) cycle(0, 0, 1'b1);
    repeat (12) cycle(0, 0, 1'b0);
    ref_w = '{6'h11, 6'h12, 6'h13, 6'h31, 6'h14, 6'h15, 6'h16, 6'h32, 6'h33};
    check_obs("backpressure", ref_w);

    // VC0 runs dry with quota left: same-cycle switch to VC1.
    reset_for(1, 1'b0);
    q0 = '{6'b01_0111};
    q1 = '{6'b11_0010};
    refresh();
    repeat (5) cycle(0, 0, 1'b0);
    ref_w = '{6'b01_0111, 6'b11_0010};
    check_obs("empty_switch", ref_w);

    // Reset while a word is in flight.
    reset_for(1, 1'b0);
    q0 = '{6'h11, 6'h12, 6'h13};
    q1 = '{6'h31};
    refresh();
    repeat (2) cycle(0, 0, 1'b0);
    reset_for(1, 1'b0);
    q0 = '{6'h1a, 6'h1b};
    q1 = '{6'h3a};
    refresh();
    repeat (6) cycle(0, 0, 1'b0);
    ref_w = '{6'h1a, 6'h1b, 6'h3a};
    check_obs("post_reset", ref_w);

    // Random traffic with sporadic backpressure.
    reset_for(1, 1'b0);
    for (int i = 0; i < 600; i++)
      cycle(35, 25, ($urandom_range(9) == 0));
    repeat (40) cycle(0, 0, 1'b0);
    check("drained_scoreboard", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
